// File: rtl/ff_jk.sv
// ---------------------------------------------------------------------------
// ff_jk: bank of WIDTH independent JK flip-flops sharing one clock.
//
// Each bit-cell updates only on the rising edge of clk. Per edge the
// command priority is: clear (all 0), then preset (all 1), then the
// per-bit J/K table:
//   j k | next q
//   0 0 | hold
//   0 1 | 0
//   1 0 | 1
//   1 1 | ~q (toggle)
//
// Ports
//   clk     in   1      clock, rising edge active
//   j       in   WIDTH  per-bit J (set) input
//   k       in   WIDTH  per-bit K (reset) input
//   preset  in   1      synchronous active-high force-to-1
//   clear   in   1      synchronous active-high reset, force-to-0
//   q       out  WIDTH  registered state
//   qNot    out  WIDTH  combinational complement of q
//
// No power-up initializer: q is undefined until the first clear, preset or
// deterministic J/K command.
// ---------------------------------------------------------------------------
module ff_jk #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic             preset,
  input  logic             clear,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qNot
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Next-state for the non-reset path. Each bit looks only at its own
  // j/k and its own current state, so the cells stay independent.
  always_comb begin
    q_d = q_q;
    if (preset) begin
      q_d = '1;
    end else begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        unique case ({j[i], k[i]})
          2'b00:   q_d[i] = q_q[i];
          2'b01:   q_d[i] = 1'b0;
          2'b10:   q_d[i] = 1'b1;
          2'b11:   q_d[i] = ~q_q[i];
          default: q_d[i] = q_q[i];
        endcase
      end
    end
  end

  // clear is sampled here so it overrides preset and J/K at the same edge.
  always_ff @(posedge clk) begin
    if (clear) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q    = q_q;
  // Derived from q, never stored, so the two outputs cannot disagree.
  assign qNot = ~q_q;

endmodule

// File: tb/tb_ff_jk.sv
// ---------------------------------------------------------------------------
// tb_ff_jk: directed self-checking bench for ff_jk.
// A WIDTH=1 instance covers the single-cell behaviour; a WIDTH=4 instance
// covers bit independence. Inputs change on falling edges, outputs are
// sampled 1 ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_ff_jk;

  logic       clk;
  logic       j1, k1, preset1, clear1;
  logic       q1, qn1;
  logic [3:0] j4, k4;
  logic       preset4, clear4;
  logic [3:0] q4, qn4;

  int total;
  int bad;

  ff_jk #(.WIDTH(1)) dut1 (
    .clk    (clk),
    .j      (j1),
    .k      (k1),
    .preset (preset1),
    .clear  (clear1),
    .q      (q1),
    .qNot   (qn1)
  );

  ff_jk #(.WIDTH(4)) dut4 (
    .clk    (clk),
    .j      (j4),
    .k      (k4),
    .preset (preset4),
    .clear  (clear4),
    .q      (q4),
    .qNot   (qn4)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Drive the 1-bit instance on a falling edge, then wait past the next
  // rising edge so outputs are stable for sampling.
  task automatic step1(input logic jv, input logic kv, input logic pv, input logic cv);
    @(negedge clk);
    j1 = jv; k1 = kv; preset1 = pv; clear1 = cv;
    @(posedge clk);
    #1;
  endtask

  task automatic step4(input logic [3:0] jv, input logic [3:0] kv, input logic pv,
                       input logic cv);
    @(negedge clk);
    j4 = jv; k4 = kv; preset4 = pv; clear4 = cv;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    // clear with everything else asserted still gives 0
    step1(1'b1, 1'b1, 1'b1, 1'b1);
    total++;
    if (q1 !== 1'b0 || qn1 !== 1'b1) begin
      bad++;
      $display("FAIL reset_all_high: q=%b qNot=%b expected q=0 qNot=1", q1, qn1);
    end
    step1(1'b0, 1'b0, 1'b0, 1'b1);
    total++;
    if (q1 !== 1'b0 || qn1 !== 1'b1) begin
      bad++;
      $display("FAIL reset_plain: q=%b qNot=%b expected q=0 qNot=1", q1, qn1);
    end
  endtask

  task automatic test_preset;
    step1(1'b0, 1'b1, 1'b1, 1'b0);
    total++;
    if (q1 !== 1'b1 || qn1 !== 1'b0) begin
      bad++;
      $display("FAIL preset_over_k: q=%b qNot=%b expected q=1 qNot=0", q1, qn1);
    end
  endtask

  task automatic test_jk_table;
    logic [1:0] jk_seq [4];
    logic       exp_q  [4];
    jk_seq = '{2'b10, 2'b00, 2'b01, 2'b00};
    exp_q  = '{1'b1, 1'b1, 1'b0, 1'b0};
    step1(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step1(jk_seq[i][1], jk_seq[i][0], 1'b0, 1'b0);
      total++;
      if (q1 !== exp_q[i] || qn1 !== ~exp_q[i]) begin
        bad++;
        $display("FAIL jk_table[%0d] jk=%b: q=%b qNot=%b expected q=%b", i, jk_seq[i], q1,
                 qn1, exp_q[i]);
      end
    end
  endtask

  task automatic test_toggle;
    logic exp_q [4];
    exp_q = '{1'b1, 1'b0, 1'b1, 1'b0};
    step1(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step1(1'b1, 1'b1, 1'b0, 1'b0);
      total++;
      if (q1 !== exp_q[i] || qn1 !== ~exp_q[i]) begin
        bad++;
        $display("FAIL toggle[%0d]: q=%b qNot=%b expected q=%b", i, q1, qn1, exp_q[i]);
      end
    end
  endtask

  task automatic test_clear_mid_toggle;
    step1(1'b0, 1'b0, 1'b0, 1'b1);
    step1(1'b1, 1'b1, 1'b0, 1'b0);  // q=1
    step1(1'b1, 1'b1, 1'b0, 1'b1);  // clear wins over toggle -> 0
    total++;
    if (q1 !== 1'b0 || qn1 !== 1'b1) begin
      bad++;
      $display("FAIL clear_mid_toggle: q=%b qNot=%b expected q=0", q1, qn1);
    end
    step1(1'b1, 1'b1, 1'b0, 1'b0);  // resumes from 0 -> 1
    total++;
    if (q1 !== 1'b1 || qn1 !== 1'b0) begin
      bad++;
      $display("FAIL toggle_resume_1: q=%b qNot=%b expected q=1", q1, qn1);
    end
    step1(1'b1, 1'b1, 1'b0, 1'b0);
    total++;
    if (q1 !== 1'b0 || qn1 !== 1'b1) begin
      bad++;
      $display("FAIL toggle_resume_0: q=%b qNot=%b expected q=0", q1, qn1);
    end
  endtask

  task automatic test_clear_preset;
    step1(1'b0, 1'b0, 1'b1, 1'b0);  // q=1
    step1(1'b0, 1'b0, 1'b1, 1'b1);
    total++;
    if (q1 !== 1'b0 || qn1 !== 1'b1) begin
      bad++;
      $display("FAIL clear_and_preset: q=%b qNot=%b expected q=0", q1, qn1);
    end
  endtask

  task automatic test_between_edges;
    step1(1'b0, 1'b0, 1'b1, 1'b0);  // q=1
    // Glitch commands between edges; none should reach q.
    #2;
    clear1 = 1'b1; preset1 = 1'b0; j1 = 1'b1; k1 = 1'b1;
    #3;
    total++;
    if (q1 !== 1'b1 || qn1 !== 1'b0) begin
      bad++;
      $display("FAIL mid_cycle_async: q=%b qNot=%b expected q=1", q1, qn1);
    end
    clear1 = 1'b0; j1 = 1'b0; k1 = 1'b0;
    step1(1'b0, 1'b0, 1'b0, 1'b0);  // hold
    total++;
    if (q1 !== 1'b1 || qn1 !== 1'b0) begin
      bad++;
      $display("FAIL between_edges_hold: q=%b qNot=%b expected q=1", q1, qn1);
    end
  endtask

  task automatic test_sweep;
    // Expected q after each vector {j,k,preset,clear}=v, starting from q=0.
    logic [15:0] exp_tbl;
    logic [3:0]  v;
    exp_tbl = 16'h5544;
    step1(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      v = 4'(i);
      step1(v[3], v[2], v[1], v[0]);
      total++;
      if (q1 !== exp_tbl[i] || qn1 !== ~exp_tbl[i]) begin
        bad++;
        $display("FAIL sweep[%b]: q=%b qNot=%b expected q=%b", v, q1, qn1, exp_tbl[i]);
      end
    end
  endtask

  task automatic test_width4;
    step4(4'b0000, 4'b0000, 1'b0, 1'b1);
    total++;
    if (q4 !== 4'b0000 || qn4 !== 4'b1111) begin
      bad++;
      $display("FAIL w4_clear: q=%b qNot=%b expected q=0000", q4, qn4);
    end
    step4(4'b0011, 4'b1100, 1'b0, 1'b0);
    total++;
    if (q4 !== 4'b0011 || qn4 !== 4'b1100) begin
      bad++;
      $display("FAIL w4_load: q=%b qNot=%b expected q=0011", q4, qn4);
    end
    step4(4'b1010, 4'b0110, 1'b0, 1'b0);
    total++;
    if (q4 !== 4'b1001 || qn4 !== 4'b0110) begin
      bad++;
      $display("FAIL w4_mixed: q=%b qNot=%b expected q=1001", q4, qn4);
    end
    step4(4'b0000, 4'b1111, 1'b1, 1'b0);
    total++;
    if (q4 !== 4'b1111 || qn4 !== 4'b0000) begin
      bad++;
      $display("FAIL w4_preset: q=%b qNot=%b expected q=1111", q4, qn4);
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    j1      = 1'b0; k1 = 1'b0; preset1 = 1'b0; clear1 = 1'b0;
    j4      = 4'b0; k4 = 4'b0; preset4 = 1'b0; clear4 = 1'b0;
    test_reset();
    test_preset();
    test_jk_table();
    test_toggle();
    test_clear_mid_toggle();
    test_clear_preset();
    test_between_edges();
    test_sweep();
    test_width4();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ff_jk.md
FF_JK -- requirements
Module: ff_jk

Interface
REQ-001 Parameter: WIDTH, default 1, number of independent JK bit-cells; all data ports are WIDTH bits wide.
REQ-002 Port: clk  input  1  single clock; all state changes occur on its rising edge only.
REQ-003 Port: clear  input  1  reset; synchronous, active-high; forces all q bits to 0.
REQ-004 Port: j  input  WIDTH  per-bit J (set) input.
REQ-005 Port: k  input  WIDTH  per-bit K (reset) input.
REQ-006 Port: preset  input  1  synchronous, active-high; forces all q bits to 1.
REQ-007 Port: q  output  WIDTH  registered flip-flop state.
REQ-008 Port: qNot  output  WIDTH  complement of q.
REQ-009 Positional port order SHALL be: clk, j, k, preset, clear, q, qNot.
REQ-010 One clock; reset is synchronous and active-high; the clock port is clk and the reset port is clear.

Function
REQ-011 q SHALL be a register updated only at the rising edge of clk; no asynchronous paths to q.
REQ-012 Priority at each rising edge SHALL be: clear, then preset, then J/K.
REQ-013 clear=1 -> q <= all 0, regardless of preset, j, k.
REQ-014 clear=0, preset=1 -> q <= all 1, regardless of j, k.
REQ-015 clear=0, preset=0 -> each bit i: j=0,k=0 hold; j=0,k=1 q[i]<=0; j=1,k=0 q[i]<=1; j=1,k=1 q[i]<=~q[i].
REQ-016 Bits SHALL be independent; no bit's next state depends on any other bit.
REQ-017 qNot SHALL equal ~q at all times, combinationally; no separate storage for qNot.
REQ-018 Latency: an effective command is visible on q one clock edge after sampling, with no extra pipeline stages.
REQ-019 With j=k=1 held, q SHALL toggle on every rising edge, giving a square wave at half the clk frequency.
REQ-020 Input changes between rising edges SHALL have no effect on q.

Reset
REQ-021 After the first rising edge with clear=1, q=0 and qNot=all 1.
REQ-022 Before any clear, preset, or deterministic J/K command, q is undefined; the design provides no power-up initializer.
REQ-023 clear asserted in the middle of a toggle sequence SHALL take effect at the next rising edge, and toggling SHALL resume from 0 after clear deasserts.
REQ-024 clear and preset asserted together -> q=0, because clear has priority.

Verification
REQ-025 Use a 20 ns clock period with inputs driven on falling edges, and compare q/qNot after each rising edge; qNot==~q must hold throughout.
REQ-026 Scenario reset: clear=1, any j, k, or preset -> q=0, qNot=1 after one edge.
REQ-027 Scenario preset: clear=0, preset=1, j=0, k=1 -> q=1, qNot=0 after one edge.
REQ-028 Scenario JK table: from q=0 apply j,k = 10 -> q=1; then 00 -> q stays 1; then 01 -> q=0; then 00 -> q stays 0.
REQ-029 Scenario toggle: from q=0, j=k=1 for 4 edges -> q sequence 1,0,1,0.
REQ-030 Scenario sweep: step {j,k,preset,clear} through 0000..1111, one value per cycle, after an initial clear.
- Any vector with clear=1 -> q=0.
- Any vector with clear=0, preset=1 -> q=1.
- Otherwise q follows the JK table.
- At end: the 1111 vector gives q=0 and the 1110 vector gives q=1.
REQ-031 Scenario WIDTH=4: j=4'b1010, k=4'b0110 from q=4'b0011 -> q=4'b1001.
